t_block_seq: RTL and testbench

T_BLOCK_SEQ -- requirements
Module: t_block_seq

---
 rtl/t_block_seq.sv | 135 +++++++++++++
 tb/tb_t_block_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/t_block_seq.sv
// Joint-table sequencer for a pipelined t_block: streams one joint per cycle into the block
// and tags each result with its joint index as it emerges LATENCY cycles later.
module t_block_seq #(
  parameter int MAX_JOINTS = 8,
  parameter int LATENCY    = 27,
  parameter int W          = 27
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [1:0]   wr_sel,
  input  logic [W-1:0] wr_data,
  input  logic         start,
  input  logic [3:0]   num_joints,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         tb_en,
  output logic [W-1:0] tb_theta,
  output logic [W-1:0] tb_alpha,
  output logic [W-1:0] tb_a,
  output logic [W-1:0] tb_d,
  output logic         out_valid,
  output logic [2:0]   out_joint
);

  localparam logic [3:0] MAX_N = 4'(MAX_JOINTS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   n_q, n_d;
  logic [2:0]   issue_q, issue_d;
  logic [3:0]   retire_q, retire_d;
  logic         err_q, err_d;
  logic [W-1:0] tbl_q [MAX_JOINTS][4];
  logic [W-1:0] fld_q [4];
  logic         vld_q [LATENCY];
  logic [2:0]   idx_q [LATENCY];

  logic         run_active, start_ok, wr_ok, load;
  logic [2:0]   load_idx;

  assign run_active = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign start_ok   = start && (num_joints != 4'd0) && (num_joints <= MAX_N);
  assign wr_ok      = wr_en && !run_active;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    n_d      = n_q;
    issue_d  = issue_q;
    retire_d = retire_q + {3'd0, out_valid};
    load     = 1'b0;
    load_idx = 3'd0;
    err_d    = run_active ? (wr_en || start)
                          : ((state_q == S_IDLE) && start && !start_ok);
    case (state_q)
      S_IDLE: begin
        issue_d  = 3'd0;
        retire_d = 4'd0;
        if (start_ok) begin
          n_d     = num_joints;
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if ({1'b0, issue_q} == n_q - 4'd1) begin
          state_d = S_DRAIN;
        end else begin
          issue_d  = issue_q + 3'd1;
          load     = 1'b1;
          load_idx = issue_q + 3'd1;
        end
      end
      S_DRAIN: if (retire_d == n_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with <= only; all next-state decisions live in always_comb.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      n_q      <= 4'd0;
      issue_q  <= 3'd0;
      retire_q <= 4'd0;
      err_q    <= 1'b0;
      // NOTE: the table is cleared explicitly so a run after reset issues zeros, not stale joints.
      for (int j = 0; j < MAX_JOINTS; j++)
        for (int f = 0; f < 4; f++) tbl_q[j][f] <= '0;
      for (int f = 0; f < 4; f++) fld_q[f] <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= 3'd0;
      end
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      err_q    <= err_d;
      if (wr_ok) tbl_q[wr_addr][wr_sel] <= wr_data;
      // A write landing in the start cycle bypasses into the first issued joint.
      if (load) begin
        for (int f = 0; f < 4; f++)
          fld_q[f] <= (wr_ok && wr_addr == load_idx && wr_sel == 2'(f)) ? wr_data
                                                                         : tbl_q[load_idx][f];
      end
      if (run_active) begin
        vld_q[0] <= (state_q == S_ISSUE);
        idx_q[0] <= (state_q == S_ISSUE) ? issue_q : 3'd0;
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end
  end

  assign busy      = run_active;
  assign tb_en     = run_active;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign tb_theta  = fld_q[0];
  assign tb_alpha  = fld_q[1];
  assign tb_a      = fld_q[2];
  assign tb_d      = fld_q[3];
  assign out_valid = vld_q[LATENCY-1];
  assign out_joint = idx_q[LATENCY-1];

endmodule

// File: tb/tb_t_block_seq.sv
// Directed bench for t_block_seq: a reference joint table plus hand-derived run timing
// (issue at s+1+k, tag at s+1+k+LATENCY, done at s+N+LATENCY+1).
module tb_t_block_seq;

  localparam int LAT = 27;
  localparam int W   = 27;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [1:0]   wr_sel;
  logic [W-1:0] wr_data;
  logic         start;
  logic [3:0]   num_joints;
  logic         busy, done, err, tb_en, out_valid;
  logic [W-1:0] tb_theta, tb_alpha, tb_a, tb_d;
  logic [2:0]   out_joint;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] mdl [8][4];

  always #5 clk = ~clk;

  t_block_seq #(.MAX_JOINTS(8), .LATENCY(LAT), .W(W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
    .wr_data(wr_data), .start(start), .num_joints(num_joints), .busy(busy), .done(done),
    .err(err), .tb_en(tb_en), .tb_theta(tb_theta), .tb_alpha(tb_alpha), .tb_a(tb_a),
    .tb_d(tb_d), .out_valid(out_valid), .out_joint(out_joint)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int j = 0; j < 8; j++)
      for (int f = 0; f < 4; f++) mdl[j][f] = '0;
  endtask

  task automatic host_write(input int addr, input int sel, input logic [W-1:0] data);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_sel = 2'(sel); wr_data = data;
    step();
    wr_en = 1'b0;
    mdl[addr][sel] = data;
  endtask

  // Compares every output against all-zero except an optional err pulse.
  task automatic check_quiet(input string tag, input logic exp_err);
    logic [7:0]     got_c, exp_c;
    logic [4*W-1:0] got_t;
    @(negedge clk);
    got_c = {busy, done, err, tb_en, out_valid, out_joint};
    exp_c = {2'b00, exp_err, 5'b00000};
    got_t = {tb_theta, tb_alpha, tb_a, tb_d};
    n_cmp++;
    if (got_c !== exp_c) begin
      n_bad++;
      $display("FAIL %s ctrl: got %b expected %b", tag, got_c, exp_c);
    end
    n_cmp++;
    if (got_t !== '0) begin
      n_bad++;
      $display("FAIL %s tb_data: got %h expected 0", tag, got_t);
    end
  endtask

  // Starts a run of n joints and checks every output cycle by cycle for n+LAT+tail cycles.
  task automatic run_check(input string tag, input int n, input int tail, input bit disturb,
                           input bit co_wr, input int co_sel, input logic [W-1:0] co_data);
    logic [7:0]     got_c, exp_c;
    logic [4*W-1:0] got_t, exp_t;
    logic           e_busy, e_done, e_err, e_vld;
    logic [2:0]     e_idx;
    int             k;
    if (co_wr) begin
      wr_en = 1'b1; wr_addr = 3'd0; wr_sel = 2'(co_sel); wr_data = co_data;
      mdl[0][co_sel] = co_data;
    end
    start = 1'b1; num_joints = 4'(n);
    step();
    start = 1'b0; wr_en = 1'b0;
    for (int j = 1; j <= n + LAT + tail; j++) begin
      if (disturb && j == 3) begin
        wr_en = 1'b1; wr_addr = 3'd2; wr_sel = 2'd1; wr_data = 27'h1AB;
      end
      if (disturb && j == 5) begin
        start = 1'b1; num_joints = 4'd3;
      end
      @(negedge clk);
      e_busy = (j <= n + LAT);
      e_done = (j == n + LAT + 1);
      e_err  = disturb && (j == 4 || j == 6);
      e_vld  = (j >= LAT + 1) && (j <= LAT + n);
      e_idx  = e_vld ? 3'(j - LAT - 1) : 3'd0;
      exp_c  = {e_busy, e_done, e_err, e_busy, e_vld, e_idx};
      got_c  = {busy, done, err, tb_en, out_valid, out_joint};
      n_cmp++;
      if (got_c !== exp_c) begin
        n_bad++;
        $display("FAIL %s ctrl cycle %0d: got %b expected %b", tag, j, got_c, exp_c);
      end
      if (e_busy) begin
        k     = (j - 1 < n - 1) ? j - 1 : n - 1;
        exp_t = {mdl[k][0], mdl[k][1], mdl[k][2], mdl[k][3]};
        got_t = {tb_theta, tb_alpha, tb_a, tb_d};
        n_cmp++;
        if (got_t !== exp_t) begin
          n_bad++;
          $display("FAIL %s tb_data cycle %0d: got %h expected %h", tag, j, got_t, exp_t);
        end
      end
      step();
      wr_en = 1'b0; start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    check_quiet("reset_state", 1'b0);
    step();
    reset = 1'b0;
    host_write(1, 0, 27'h55);
    host_write(0, 3, 27'h77);
    // Reset wins over a simultaneous write and start; table contents return to zero.
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_sel = 2'd0; wr_data = 27'h99;
    start = 1'b1; num_joints = 4'd2;
    step();
    reset = 1'b0; wr_en = 1'b0; start = 1'b0;
    check_quiet("reset_priority", 1'b0);
    clear_model();
    run_check("post_reset_run", 2, 3, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_single_joint();
    host_write(0, 0, 27'h40);
    host_write(0, 2, 27'h100);
    run_check("single_joint", 1, 3, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_full_table();
    for (int j = 0; j < 8; j++)
      for (int f = 0; f < 4; f++) host_write(j, f, 27'h10000 * (j + 1) + 27'h100 * f + 27'(j));
    run_check("full_table", 8, 1, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_back_to_back();
    run_check("back_to_back", 3, 3, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_illegal_start();
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; num_joints = (i == 0) ? 4'd0 : 4'd9;
      step();
      start = 1'b0;
      check_quiet_ctrl_only((i == 0) ? "illegal_n0" : "illegal_n9", 1'b1);
      step();
      check_quiet_ctrl_only("illegal_after", 1'b0);
      step();
    end
  endtask

  // Control-only variant for moments when tb_* legitimately hold a previous run's joint.
  task automatic check_quiet_ctrl_only(input string tag, input logic exp_err);
    logic [7:0] got_c, exp_c;
    @(negedge clk);
    got_c = {busy, done, err, tb_en, out_valid, out_joint};
    exp_c = {2'b00, exp_err, 5'b00000};
    n_cmp++;
    if (got_c !== exp_c) begin
      n_bad++;
      $display("FAIL %s ctrl: got %b expected %b", tag, got_c, exp_c);
    end
  endtask

  task automatic test_busy_reject();
    run_check("busy_reject", 4, 3, 1'b1, 1'b0, 0, '0);
    run_check("busy_reject_table", 4, 3, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic test_same_cycle_write();
    run_check("same_cycle_write", 1, 3, 1'b0, 1'b1, 3, 27'h200);
  endtask

  task automatic test_mid_run_reset();
    start = 1'b1; num_joints = 4'd8;
    step();
    start = 1'b0;
    repeat (14) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_model();
    for (int j = 0; j < 40; j++) begin
      check_quiet("abort_quiet", 1'b0);
      step();
    end
    host_write(0, 1, 27'h3C);
    host_write(1, 2, 27'h5A5);
    run_check("after_abort", 2, 3, 1'b0, 1'b0, 0, '0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_sel = '0; wr_data = '0;
    start = 1'b0; num_joints = '0;
    clear_model();
    test_reset();
    test_single_joint();
    test_full_table();
    test_back_to_back();
    test_illegal_start();
    test_busy_reject();
    test_same_cycle_write();
    test_mid_run_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
